// File: rtl/dual_debounce_pkg.sv
// Shared definitions for the dual-channel debouncer: FSM state encoding
// and default parameter values.
package dual_debounce_pkg;

  // Per-channel debounce state; encoding is fixed so it can be probed externally.
  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    LO_TO_HI  = 2'd1,
    HI_STABLE = 2'd2,
    HI_TO_LO  = 2'd3
  } db_state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DB_CYCLES_DEF   = 1000;
  localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: raw-input synchronizer, stability counter and
// four-state FSM with a registered level output.
// Optional edge pulses are built with DUAL_DEBOUNCE_EDGE_EN defined.
module debounce_channel
  import dual_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
`ifdef DUAL_DEBOUNCE_EDGE_EN
  ,
  output logic rise_o,
  output logic fall_o
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  logic [CNT_W-1:0]       cnt_q;
  logic                   cnt_last;
  db_state_e              state_q;
  logic                   level_q;

  assign sync_in  = sync_q[SYNC_STAGES-1];
  // The entry into a *_TO_* state already counts as the first differing
  // cycle, so DB_CYCLES-1 marks the last one before the level is accepted.
  assign cnt_last = (cnt_q == CNT_W'(DB_CYCLES - 1));

  // Shift the asynchronous raw input through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

`ifdef DUAL_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;
`endif

  // Debounce FSM: qualify a new level only after DB_CYCLES consecutive
  // synchronized samples that differ from the current output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LO_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
`ifdef DUAL_DEBOUNCE_EDGE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
`ifdef DUAL_DEBOUNCE_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      case (state_q)
        LO_STABLE: begin
          if (sync_in) begin
            state_q <= LO_TO_HI;
            cnt_q   <= CNT_W'(1);
          end
        end
        LO_TO_HI: begin
          if (!sync_in) begin
            state_q <= LO_STABLE;
            cnt_q   <= '0;
          end else if (cnt_last) begin
            state_q <= HI_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b1;
`ifdef DUAL_DEBOUNCE_EDGE_EN
            rise_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HI_STABLE: begin
          if (!sync_in) begin
            state_q <= HI_TO_LO;
            cnt_q   <= CNT_W'(1);
          end
        end
        HI_TO_LO: begin
          if (sync_in) begin
            state_q <= HI_STABLE;
            cnt_q   <= '0;
          end else if (cnt_last) begin
            state_q <= LO_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
`ifdef DUAL_DEBOUNCE_EDGE_EN
            fall_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= LO_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
`ifdef DUAL_DEBOUNCE_EDGE_EN
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
`endif

endmodule

// File: rtl/dual_debounce.sv
// Two independent debounce channels feeding a downstream AND stage.
// Define DUAL_DEBOUNCE_EDGE_EN to add registered rise/fall pulse outputs.
module dual_debounce
  import dual_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b
`ifdef DUAL_DEBOUNCE_EDGE_EN
  ,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
`endif
);

  // Channel A debouncer.
  debounce_channel #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_a (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (a_raw),
    .level_o(a)
`ifdef DUAL_DEBOUNCE_EDGE_EN
    ,
    .rise_o (a_rise),
    .fall_o (a_fall)
`endif
  );

  // Channel B debouncer.
  debounce_channel #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_b (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (b_raw),
    .level_o(b)
`ifdef DUAL_DEBOUNCE_EDGE_EN
    ,
    .rise_o (b_rise),
    .fall_o (b_fall)
`endif
  );

endmodule

// File: tb/tb_dual_debounce.sv
// Directed self-checking bench for dual_debounce (SYNC_STAGES=2, DB_CYCLES=4).
module tb_dual_debounce;

  logic clk;
  logic rst;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;

  int errors = 0;
  int checks = 0;
  int fall_cnt;

  dual_debounce #(
    .SYNC_STAGES(2),
    .DB_CYCLES  (4),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a     (a),
    .b     (b)
`ifdef DUAL_DEBOUNCE_EDGE_EN
    ,
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
`endif
  );

`ifndef DUAL_DEBOUNCE_EDGE_EN
  assign a_rise = 1'b0;
  assign a_fall = 1'b0;
  assign b_rise = 1'b0;
  assign b_fall = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_a", 32'(a), 32'd0);
    chk("reset_b", 32'(b), 32'd0);
    chk("reset_edges", 32'({a_rise, a_fall, b_rise, b_fall}), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Quiet inputs: nothing moves for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ab", 32'({a, b}), 32'd0);
      chk("idle_edges", 32'({a_rise, a_fall, b_rise, b_fall}), 32'd0);
    end

    // Clean step on A: output rises on the 6th edge, rise pulses once.
    a_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("a_step_a_%0d", i), 32'(a), 32'(i >= 6));
      chk($sformatf("a_step_b_%0d", i), 32'(b), 32'd0);
`ifdef DUAL_DEBOUNCE_EDGE_EN
      chk($sformatf("a_step_rise_%0d", i), 32'(a_rise), 32'(i == 6));
`endif
    end
    tick();
    chk("a_step_hold", 32'(a), 32'd1);
    chk("a_step_rise_once", 32'(a_rise), 32'd0);

    // Short pulse on B: three synchronized high cycles are rejected.
    b_raw = 1'b1;
    tick();
    tick();
    tick();
    b_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("b_glitch_b", 32'(b), 32'd0);
      chk("b_glitch_rise", 32'(b_rise), 32'd0);
    end
    chk("b_glitch_cnt", 32'(dut.u_b.cnt_q), 32'd0);
    chk("b_glitch_state", 32'(dut.u_b.state_q), 32'd0);

    // Clean fall on A: output drops on the 6th edge.
    a_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("a_fall_a_%0d", i), 32'(a), 32'(i < 6));
`ifdef DUAL_DEBOUNCE_EDGE_EN
      chk($sformatf("a_fall_pulse_%0d", i), 32'(a_fall), 32'(i == 6));
`endif
    end

    // Simultaneous steps on both channels resolve together.
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("sim_a_%0d", i), 32'(a), 32'(i >= 6));
      chk($sformatf("sim_b_%0d", i), 32'(b), 32'(i >= 6));
      chk($sformatf("sim_and_%0d", i), 32'(a & b), 32'(i >= 6));
    end

    // Return to a clean low state through reset.
    a_raw = 1'b0;
    b_raw = 1'b0;
    rst   = 1'b1;
    #1;
    chk("rst_async_ab", 32'({a, b}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();

    // Reset mid-qualification abandons the count; full latency afterwards.
    a_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_pre_a", 32'(a), 32'd0);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_a", 32'(a), 32'd0);
    chk("mid_rst_cnt", 32'(dut.u_a.cnt_q), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("post_rst_a_%0d", i), 32'(a), 32'(i >= 6));
    end
    tick();
    tick();

    // A high: low 2, high 1, then low held; falls 6 edges into the held low.
    fall_cnt = 0;
    a_raw = 1'b0;
    tick();
    fall_cnt += int'(a_fall);
    chk("bounce_a_1", 32'(a), 32'd1);
    tick();
    fall_cnt += int'(a_fall);
    chk("bounce_a_2", 32'(a), 32'd1);
    a_raw = 1'b1;
    tick();
    fall_cnt += int'(a_fall);
    chk("bounce_a_3", 32'(a), 32'd1);
    a_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      fall_cnt += int'(a_fall);
      chk($sformatf("bounce_hold_a_%0d", i), 32'(a), 32'(i < 6));
    end
    tick();
    fall_cnt += int'(a_fall);
    tick();
    fall_cnt += int'(a_fall);
    chk("bounce_final_a", 32'(a), 32'd0);
`ifdef DUAL_DEBOUNCE_EDGE_EN
    chk("bounce_fall_once", 32'(fall_cnt), 32'd1);
`else
    chk("bounce_fall_none", 32'(fall_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
